// File: rtl/pe_partition_scheduler_pkg.sv
// Shared types for the per-PE partition scheduler: FSM states, phase mode and
// the control-port encodings.
package pe_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Mode value doubles as the table bank select: 0 = shard bank, 1 = bin bank.
  typedef enum logic {
    MODE_SCATTER = 1'b0,
    MODE_GATHER  = 1'b1
  } mode_t;

  localparam logic [1:0] CTRL_NONE     = 2'b00;
  localparam logic [1:0] CTRL_SCATTER  = 2'b01;
  localparam logic [1:0] CTRL_GATHER   = 2'b10;
  localparam logic [1:0] CTRL_RESERVED = 2'b11;

endpackage

// File: rtl/pe_partition_scheduler_par_table.sv
// Two-bank partition table (shard bank 0, bin bank 1): one cfg write port and
// one combinational read port addressed by the scheduler pointer.
module par_table
  import pe_sched_pkg::*;
#(
  parameter int unsigned       PAR_NUM    = 32,
  parameter int unsigned       PAR_NUM_W  = 5,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       SIZE_W     = 32,
  parameter logic [ADDR_W-1:0] SHARD_BASE = 32'h0004_0000,
  parameter logic [ADDR_W-1:0] BIN_BASE   = 32'h4004_0000,
  parameter logic [ADDR_W-1:0] SLOT_SIZE  = 32'h0200_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [PAR_NUM_W-1:0] wr_id,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [SIZE_W-1:0]    wr_size,
  input  logic [PAR_NUM_W-1:0] rd_ptr,
  input  mode_t                rd_sel,
  output logic [ADDR_W-1:0]    rd_addr_c,
  output logic [SIZE_W-1:0]    rd_size_c
);

  logic [ADDR_W-1:0] addr_q [2][PAR_NUM];
  logic [SIZE_W-1:0] size_q [2][PAR_NUM];

  // Reset lays the partitions out back to back at SLOT_SIZE stride (wrapping).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PAR_NUM); i++) begin
        addr_q[0][i] <= SHARD_BASE + ADDR_W'(i) * SLOT_SIZE;
        addr_q[1][i] <= BIN_BASE + ADDR_W'(i) * SLOT_SIZE;
        size_q[0][i] <= SIZE_W'(SLOT_SIZE);
        size_q[1][i] <= SIZE_W'(SLOT_SIZE);
      end
    end else if (wr_en && (32'(wr_id) < PAR_NUM)) begin
      addr_q[wr_sel][wr_id] <= wr_addr;
      size_q[wr_sel][wr_id] <= wr_size;
    end
  end

  assign rd_addr_c = addr_q[rd_sel][rd_ptr];
  assign rd_size_c = size_q[rd_sel][rd_ptr];

endmodule

// File: rtl/pe_partition_scheduler.sv
// Per-PE partition scheduler: walks the partition table once per phase, offers
// one job at a time over valid/ready and pulses pe_done when the phase ends.
module pe_partition_scheduler
  import pe_sched_pkg::*;
#(
  parameter int unsigned       PAR_NUM    = 32,
  parameter int unsigned       PAR_NUM_W  = 5,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       SIZE_W     = 32,
  parameter logic [ADDR_W-1:0] SHARD_BASE = 32'h0004_0000,
  parameter logic [ADDR_W-1:0] BIN_BASE   = 32'h4004_0000,
  parameter logic [ADDR_W-1:0] SLOT_SIZE  = 32'h0200_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           control,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [PAR_NUM_W-1:0] cfg_id,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [SIZE_W-1:0]    cfg_size,
  output logic                 job_valid,
  input  logic                 job_ready,
  output logic [PAR_NUM_W-1:0] job_id,
  output logic [ADDR_W-1:0]    job_addr,
  output logic [SIZE_W-1:0]    job_size,
  input  logic                 par_complete_sig,
  input  logic                 par_active,
  output logic                 busy,
  output logic                 pe_done,
  output logic [PAR_NUM_W:0]   active_count
);

  localparam int unsigned          CNT_W = PAR_NUM_W + 1;
  localparam logic [PAR_NUM_W-1:0] LAST  = PAR_NUM_W'(PAR_NUM - 1);

  state_t               state, next_state;
  mode_t                mode;
  logic [PAR_NUM_W-1:0] ptr;
  logic [PAR_NUM-1:0]   active;
  logic [ADDR_W-1:0]    tbl_addr_c;
  logic [SIZE_W-1:0]    tbl_size_c;
  logic                 skip_c, last_c;
  logic                 start_c, advance_c, load_c, accept_c, complete_c;
  logic [CNT_W-1:0]     pop_c;

  par_table #(
    .PAR_NUM   (PAR_NUM),
    .PAR_NUM_W (PAR_NUM_W),
    .ADDR_W    (ADDR_W),
    .SIZE_W    (SIZE_W),
    .SHARD_BASE(SHARD_BASE),
    .BIN_BASE  (BIN_BASE),
    .SLOT_SIZE (SLOT_SIZE)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cfg_we && (state == ST_IDLE)),
    .wr_sel   (cfg_sel),
    .wr_id    (cfg_id),
    .wr_addr  (cfg_addr),
    .wr_size  (cfg_size),
    .rd_ptr   (ptr),
    .rd_sel   (mode),
    .rd_addr_c(tbl_addr_c),
    .rd_size_c(tbl_size_c)
  );

  assign last_c = (ptr == LAST);
  assign skip_c = (tbl_size_c == '0) || ((mode == MODE_SCATTER) && !active[ptr]);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state plus the single-cycle datapath strobes.
  always_comb begin
    next_state = state;
    start_c    = 1'b0;
    advance_c  = 1'b0;
    load_c     = 1'b0;
    accept_c   = 1'b0;
    complete_c = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if ((control != CTRL_NONE) && (control != CTRL_RESERVED)) begin
          start_c    = 1'b1;
          next_state = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!skip_c) begin
          load_c     = 1'b1;
          next_state = ST_ISSUE;
        end else if (last_c) begin
          next_state = ST_DONE;
        end else begin
          advance_c = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (job_valid && job_ready) begin
          accept_c   = 1'b1;
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (par_complete_sig) begin
          complete_c = 1'b1;
          if (last_c) begin
            next_state = ST_DONE;
          end else begin
            advance_c  = 1'b1;
            next_state = ST_SCAN;
          end
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(PAR_NUM); i++) pop_c = pop_c + CNT_W'(active[i]);
  end

  // Registered outputs follow next_state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode         <= MODE_SCATTER;
      ptr          <= '0;
      active       <= '1;
      active_count <= CNT_W'(PAR_NUM);
      job_valid    <= 1'b0;
      job_id       <= '0;
      job_addr     <= '0;
      job_size     <= '0;
      busy         <= 1'b0;
      pe_done      <= 1'b0;
    end else begin
      job_valid    <= (next_state == ST_ISSUE);
      busy         <= (next_state != ST_IDLE);
      pe_done      <= (next_state == ST_DONE);
      active_count <= pop_c;
      if (start_c) begin
        mode <= (control == CTRL_SCATTER) ? MODE_SCATTER : MODE_GATHER;
        ptr  <= '0;
      end else if (advance_c) begin
        ptr <= ptr + PAR_NUM_W'(1);
      end
      if (load_c) begin
        job_id   <= ptr;
        job_addr <= tbl_addr_c;
        job_size <= tbl_size_c;
      end
      if (accept_c && (mode == MODE_SCATTER)) active[ptr] <= 1'b0;
      if (complete_c && (mode == MODE_GATHER)) active[ptr] <= par_active;
    end
  end

endmodule

// File: tb/tb_pe_partition_scheduler.sv
// Randomised self-checking bench for pe_partition_scheduler (PAR_NUM = 4),
// checked against a partition-walk reference model.
module tb_pe_partition_scheduler;

  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  control;
  logic        cfg_we, cfg_sel;
  logic [1:0]  cfg_id;
  logic [31:0] cfg_addr, cfg_size;
  logic        job_valid, job_ready;
  logic [1:0]  job_id;
  logic [31:0] job_addr, job_size;
  logic        par_complete_sig, par_active;
  logic        busy, pe_done;
  logic [2:0]  active_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_addr [2][NP];
  logic [31:0] m_size [2][NP];
  bit          m_act  [NP];

  // Observations from the most recent phase
  int          o_id[$], o_rise[$], o_cpl[$];
  logic [31:0] o_addr[$], o_size[$];
  int          o_done_cnt, o_done_cyc, o_busy_after, o_proto, o_timeout;

  pe_partition_scheduler #(
    .PAR_NUM(4), .PAR_NUM_W(2), .ADDR_W(32), .SIZE_W(32),
    .SHARD_BASE(32'h1000), .BIN_BASE(32'h2000), .SLOT_SIZE(32'h100)
  ) dut (
    .clk(clk), .rst(rst), .control(control),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_id(cfg_id), .cfg_addr(cfg_addr), .cfg_size(cfg_size),
    .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id), .job_addr(job_addr), .job_size(job_size),
    .par_complete_sig(par_complete_sig), .par_active(par_active),
    .busy(busy), .pe_done(pe_done), .active_count(active_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_addr[0][p] = 32'h1000 + 32'(p) * 32'h100;
      m_addr[1][p] = 32'h2000 + 32'(p) * 32'h100;
      m_size[0][p] = 32'h100;
      m_size[1][p] = 32'h100;
      m_act[p]     = 1'b1;
    end
  endtask

  task automatic cfg_write(input bit sel, input int id, input logic [31:0] a, input logic [31:0] s);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_id = 2'(id); cfg_addr = a; cfg_size = s;
    @(negedge clk);
    cfg_we = 1'b0;
    m_addr[sel][id] = a;
    m_size[sel][id] = s;
  endtask

  // One full phase: drive a PE responder, then compare against the partition walk.
  // rmode 0: always ready, 1: random ready + stray inputs, 2: hold first offer 10 cycles.
  task automatic test_phase(input string tag, input bit gather, input int rmode,
                            input int dly, input logic [NP-1:0] pa, input bit stray_cfg);
    int cyc, wait_cpl, cur_id, hold_left, slot, n, pop;
    bit in_offer, pending;
    int e_id[$], e_rise[$];
    logic [31:0] e_addr[$], e_size[$];
    o_id.delete(); o_rise.delete(); o_cpl.delete(); o_addr.delete(); o_size.delete();
    o_done_cnt = 0; o_done_cyc = -1; o_busy_after = -1; o_proto = 0; o_timeout = 0;
    in_offer = 0; pending = 0; wait_cpl = 0; cur_id = 0;
    hold_left = (rmode == 2) ? 10 : 0;
    @(negedge clk);
    control = gather ? 2'b10 : 2'b01;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      control = 2'b00; job_ready = 1'b0; par_complete_sig = 1'b0; cfg_we = 1'b0;
      if (o_done_cnt == 0 && busy !== 1'b1) o_proto++;
      if (pe_done === 1'b1) begin
        if (o_done_cnt == 0) o_done_cyc = cyc;
        o_done_cnt++;
      end
      if (job_valid === 1'b1) begin
        if (pending) o_proto++;
        if (!in_offer) begin
          o_id.push_back(int'(job_id)); o_addr.push_back(job_addr);
          o_size.push_back(job_size); o_rise.push_back(cyc);
          in_offer = 1;
        end else if (int'(job_id) != o_id[$] || job_addr !== o_addr[$] || job_size !== o_size[$]) begin
          o_proto++;
        end
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 5) begin par_complete_sig = 1'b1; par_active = 1'b1; end
        end else if (rmode == 1) begin
          job_ready = ($urandom_range(0, 2) != 0);
        end else begin
          job_ready = 1'b1;
        end
        if (rmode == 1 && !job_ready && $urandom_range(0, 3) == 0) begin
          par_complete_sig = 1'b1; par_active = 1'($urandom_range(0, 1));
        end
        if (job_ready) begin
          in_offer = 0; pending = 1; cur_id = int'(job_id);
          wait_cpl = (dly > 0) ? dly : int'($urandom_range(1, 4));
        end
      end else begin
        if (in_offer) begin o_proto++; in_offer = 0; end
        if (pending) begin
          wait_cpl--;
          if (wait_cpl == 0) begin
            par_complete_sig = 1'b1; par_active = pa[cur_id]; pending = 0;
            o_cpl.push_back(cyc);
          end
        end
      end
      if (stray_cfg && cyc == 2) begin
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_id = 2'd3; cfg_addr = 32'hDEAD_0000; cfg_size = 32'h0;
      end
      if (rmode == 1 && o_done_cnt == 0 && $urandom_range(0, 5) == 0) control = 2'($urandom_range(1, 3));
      if (o_done_cnt > 0 && cyc == o_done_cyc + 1) begin o_busy_after = int'(busy); break; end
      if (cyc >= 400) begin o_timeout = 1; break; end
    end
    control = 2'b00; job_ready = 1'b0; par_complete_sig = 1'b0; cfg_we = 1'b0;

    // Reference walk: each partition takes one slot if skipped, else waits for its completion.
    slot = 1; n = 0;
    for (int p = 0; p < NP; p++) begin
      if (m_size[gather][p] == 0 || (!gather && !m_act[p])) begin
        slot++;
      end else begin
        e_id.push_back(p); e_addr.push_back(m_addr[gather][p]);
        e_size.push_back(m_size[gather][p]); e_rise.push_back(slot + 1);
        m_act[p] = gather ? bit'(pa[p]) : 1'b0;
        slot = (n < o_cpl.size()) ? o_cpl[n] + 1 : -1000;
        n++;
      end
    end
    pop = 0;
    for (int p = 0; p < NP; p++) pop += int'(m_act[p]);

    vectors++;
    if (o_timeout != 0) begin
      miscompares++; $display("FAIL %s timeout: got no pe_done in 400 cycles, want pe_done", tag);
    end
    vectors++;
    if (o_id.size() != n) begin
      miscompares++; $display("FAIL %s job count: got %0d want %0d", tag, o_id.size(), n);
    end
    for (int i = 0; i < n && i < o_id.size(); i++) begin
      vectors++;
      if (o_id[i] != e_id[i] || o_addr[i] !== e_addr[i] || o_size[i] !== e_size[i] || o_rise[i] != e_rise[i]) begin
        miscompares++;
        $display("FAIL %s job%0d: got id %0d addr %h size %h at cyc %0d, want id %0d addr %h size %h at cyc %0d",
                 tag, i, o_id[i], o_addr[i], o_size[i], o_rise[i], e_id[i], e_addr[i], e_size[i], e_rise[i]);
      end
    end
    vectors++;
    if (o_done_cnt != 1) begin
      miscompares++; $display("FAIL %s pe_done count: got %0d want 1", tag, o_done_cnt);
    end
    vectors++;
    if (o_done_cyc != slot) begin
      miscompares++; $display("FAIL %s pe_done cycle: got %0d want %0d", tag, o_done_cyc, slot);
    end
    vectors++;
    if (o_busy_after != 0) begin
      miscompares++; $display("FAIL %s busy after done: got %0d want 0", tag, o_busy_after);
    end
    vectors++;
    if (o_proto != 0) begin
      miscompares++; $display("FAIL %s handshake/busy protocol: got %0d violations want 0", tag, o_proto);
    end
    vectors++;
    if (int'(active_count) != pop) begin
      miscompares++; $display("FAIL %s active_count: got %0d want %0d", tag, active_count, pop);
    end
    if (o_timeout != 0) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (job_valid !== 1'b0) begin miscompares++; $display("FAIL reset job_valid: got %b want 0", job_valid); end
    vectors++; if (pe_done !== 1'b0) begin miscompares++; $display("FAIL reset pe_done: got %b want 0", pe_done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
    vectors++; if (job_id !== 2'd0) begin miscompares++; $display("FAIL reset job_id: got %0d want 0", job_id); end
    vectors++; if (job_addr !== 32'h0) begin miscompares++; $display("FAIL reset job_addr: got %h want 0", job_addr); end
    vectors++; if (job_size !== 32'h0) begin miscompares++; $display("FAIL reset job_size: got %h want 0", job_size); end
    vectors++; if (active_count !== 3'd4) begin miscompares++; $display("FAIL reset active_count: got %0d want 4", active_count); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_scatter_full();
    test_phase("scatter_full", 1'b0, 0, 3, 4'b0000, 1'b0);
  endtask

  task automatic test_gather_mask();
    test_phase("gather_mask", 1'b1, 0, 3, 4'b0101, 1'b0);
    test_phase("scatter_masked", 1'b0, 0, 3, 4'b0000, 1'b0);
  endtask

  task automatic test_all_inactive();
    test_phase("scatter_none", 1'b0, 0, 2, 4'b0000, 1'b0);
  endtask

  task automatic test_cfg_skip();
    test_phase("gather_reactivate", 1'b1, 0, 2, 4'b1111, 1'b0);
    cfg_write(1'b0, 1, 32'hABC0, 32'h0);
    test_phase("scatter_cfg_skip", 1'b0, 0, 2, 4'b0000, 1'b1);
  endtask

  task automatic test_ready_hold();
    test_phase("gather_ready_hold", 1'b1, 2, 2, 4'($urandom), 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      for (int w = 0; w < 2; w++) begin
        cfg_write(1'($urandom_range(0, 1)), int'($urandom_range(0, NP - 1)), $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 32'h0010_0000)));
      end
      test_phase("random", 1'($urandom_range(0, 1)), 1, 0, 4'($urandom), 1'b0);
    end
  endtask

  task automatic test_reset_midphase();
    bit found, pend;
    int dones;
    rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
    found = 0; pend = 0;
    @(negedge clk);
    control = 2'b01;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      control = 2'b00; job_ready = 1'b1; par_complete_sig = 1'b0;
      if (pend) begin
        par_complete_sig = 1'b1; par_active = 1'b0; pend = 0;
      end else if (job_valid === 1'b1) begin
        if (job_id == 2'd2) found = 1;
        else pend = 1;
      end
    end
    @(negedge clk);
    job_ready = 1'b0; par_complete_sig = 1'b0; rst = 1'b1;
    @(negedge clk);
    vectors++; if (!found) begin miscompares++; $display("FAIL midrst reach job2: got not reached want reached"); end
    vectors++; if (job_valid !== 1'b0) begin miscompares++; $display("FAIL midrst job_valid: got %b want 0", job_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst busy: got %b want 0", busy); end
    vectors++; if (pe_done !== 1'b0) begin miscompares++; $display("FAIL midrst pe_done: got %b want 0", pe_done); end
    vectors++;
    if (job_id !== 2'd0 || job_addr !== 32'h0 || job_size !== 32'h0) begin
      miscompares++; $display("FAIL midrst job fields: got %0d/%h/%h want 0/0/0", job_id, job_addr, job_size);
    end
    vectors++; if (active_count !== 3'd4) begin miscompares++; $display("FAIL midrst active_count: got %0d want 4", active_count); end
    rst = 1'b0;
    model_reset();
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (pe_done !== 1'b0) dones++;
    end
    vectors++; if (dones != 0) begin miscompares++; $display("FAIL midrst stray pe_done: got %0d want 0", dones); end
    test_phase("scatter_after_rst", 1'b0, 0, 1, 4'b0000, 1'b0);
  endtask

  initial begin
    rst = 1'b1; control = 2'b00; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_id = 2'd0;
    cfg_addr = 32'h0; cfg_size = 32'h0; job_ready = 1'b0; par_complete_sig = 1'b0; par_active = 1'b0;
    test_reset();
    test_scatter_full();
    test_gather_mask();
    test_all_inactive();
    test_cfg_skip();
    test_ready_hold();
    test_random();
    test_reset_midphase();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_partition_scheduler.md
# pe_partition_scheduler

Parametrised per-PE partition scheduler for the scatter/gather graph engine. It walks a programmable partition table and hands one job at a time (shard in scatter, bin in gather) to the PE pipeline over a valid/ready handshake. It tracks per-partition active flags so scatter skips inactive partitions, and it raises a one-cycle done pulse after the last partition of a phase completes.

## Interface
- PAR_NUM, 32: partitions per PE; must be ≥ 2.
- PAR_NUM_W, 5: partition index width, equal to clog2(PAR_NUM).
- ADDR_W, 32: job address width.
- SIZE_W, 32: job size width.
- SHARD_BASE, 32'h0004_0000: reset base address of the shard region.
- BIN_BASE, 32'h4004_0000: reset base address of the bin region.
- SLOT_SIZE, 32'h0200_0000: reset per-partition stride and size.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- control  in  2  00 none, 01 scatter, 10 gather, 11 reserved (ignored); sampled only in IDLE.
- cfg_we  in  1  table write strobe; accepted only in IDLE.
- cfg_sel  in  1  0 = shard entry, 1 = bin entry.
- cfg_id  in  PAR_NUM_W  entry index; ids ≥ PAR_NUM are ignored.
- cfg_addr  in  ADDR_W  entry address.
- cfg_size  in  SIZE_W  entry size.
- job_valid  out  1  job offer.
- job_ready  in  1  PE accepts the job.
- job_id  out  PAR_NUM_W  partition index.
- job_addr  out  ADDR_W  shard or bin address.
- job_size  out  SIZE_W  shard or bin size.
- par_complete_sig  in  1  PE finished the current job.
- par_active  in  1  gather result: the partition is active for the next scatter; sampled with par_complete_sig.
- busy  out  1  state ≠ IDLE.
- pe_done  out  1  one-cycle phase-complete pulse.
- active_count  out  PAR_NUM_W+1  number of set active flags.

## Operation
- States are IDLE, SCAN, ISSUE, WAIT and DONE. The mode (scatter or gather) is latched on leaving IDLE.
- IDLE: when control is 01 or 10, latch the mode, set ptr=0 and go to SCAN. Otherwise stay in IDLE. cfg writes land here.
- SCAN: skip the entry when the selected size is 0, or when the mode is scatter and active[ptr] is 0.
  - On skip: if ptr = PAR_NUM-1, go to DONE; else ptr++ and stay in SCAN.
  - On no skip: go to ISSUE.
- ISSUE: job_valid=1; job_id, job_addr and job_size come from the table and stay stable until the handshake.
  - On job_valid & job_ready: go to WAIT.
  - In scatter mode the handshake also clears active[ptr].
- WAIT: on par_complete_sig:
  - In gather mode, active[ptr] ← par_active.
  - If ptr = PAR_NUM-1, go to DONE; else ptr++ and go to SCAN.
- DONE: pe_done=1 for this single cycle, then go to IDLE.
- Every partition 0..PAR_NUM-1, including the last, is considered once per phase.
- par_complete_sig outside WAIT, control outside IDLE, and cfg_we outside IDLE are all ignored.
- Table contents and active flags persist across phases. Only rst reinitialises them.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset values:
  - State IDLE; job_valid=0, pe_done=0, busy=0.
  - job_id, job_addr, job_size = 0.
  - active_count = PAR_NUM.
  - Entry i: shard addr = SHARD_BASE+i·SLOT_SIZE; bin addr = BIN_BASE+i·SLOT_SIZE; both sizes = SLOT_SIZE.
  - All active flags = 1.
- rst mid-phase aborts the phase immediately and applies the reset values; no pe_done is produced.
- Latencies:
  - control is sampled in cycle t; SCAN occurs in t+1; job_valid rises no earlier than t+2.
  - Each skipped partition costs one cycle.
  - From par_complete_sig to the next job_valid is two cycles (SCAN then ISSUE) when no entries are skipped.
- Handshake outputs:
  - job_valid is registered.
  - job_valid never drops without job_ready.
  - job_valid is low in the cycle after acceptance.
- pe_done timing: pe_done is high exactly one cycle after the last completion, or after the last skip. busy falls the cycle after pe_done.
- A scatter phase with all partitions inactive takes PAR_NUM SCAN cycles, then pe_done. No job is issued.
- Active-flag updates:
  - active_count updates one cycle after any active-flag change.
  - If handshake or completion and a flag update coincide, the flag update wins.

## Structure
- Shared package pe_sched_pkg:
  - state enum (IDLE, SCAN, ISSUE, WAIT, DONE).
  - mode enum.
  - control encodings CTRL_NONE, CTRL_SCATTER, CTRL_GATHER.
- Sub-module par_table:
  - Two-bank register file (shard and bin), indexed by partition.
  - One write port (cfg) and one combinational read port (ptr, mode).
  - Reset-initialised from parameters.
- Active flags and the population counter stay in the top module.

## Test plan
All scenarios use PAR_NUM=4, SLOT_SIZE=0x100, SHARD_BASE=0x1000 and BIN_BASE=0x2000.
- Reset, then scatter with job_ready=1 and completion 3 cycles after each accept: jobs 0..3 at addrs 0x1000/0x1100/0x1200/0x1300, size 0x100, then one pe_done. active_count ends at 0.
- Gather after that scatter with par_active = 1,0,1,0: addrs 0x2000..0x2300. active ends as {1,0,1,0} and active_count=2. The next scatter issues only ids 0 and 2, and pe_done follows the id-2 completion.
- Scatter with all flags clear: no job_valid, pe_done exactly 5 cycles after the control sample.
- cfg write of shard id 1 to addr 0xABC0, size 0 while IDLE: scatter skips id 1. The same write issued while busy is ignored.
- job_ready held low 10 cycles: job_valid and its fields stay stable. A stray par_complete_sig during ISSUE is ignored.
- rst asserted in WAIT of job 2: next cycle all outputs are at reset values and there is no pe_done. A new scatter restarts at id 0.
